// File: rtl/hist_pkg.sv
// Shared definitions for the histogram / equalisation LUT blocks.
package hist_pkg;

  localparam int unsigned HIST_BINS = 256;
  localparam int unsigned PIX_W     = 8;
  localparam int unsigned BIN_W     = 16;
  localparam int unsigned PIX_MAX   = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } hist_state_e;

endpackage : hist_pkg

// File: rtl/hist_eq_lut_ram.sv
// 256x8 equalisation LUT: synchronous write port, synchronous read port.
// The read register can return the read address itself (pass-through mapping).
module hist_eq_lut_ram
  import hist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PIX_W-1:0] wr_addr,
  input  logic [PIX_W-1:0] wr_data,
  input  logic [PIX_W-1:0] rd_addr,
  input  logic             rd_bypass,
  output logic [PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [HIST_BINS];

  // Storage is deliberately unreset; stale contents are masked by rd_bypass.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= rd_bypass ? rd_addr : mem[rd_addr];
    end
  end

endmodule : hist_eq_lut_ram

// File: rtl/hist_eq_lut_builder.sv
// Builds a histogram-equalisation LUT from a completed histogram and remaps pixels.
// Optional macro HIST_EQ_ROUND_EN selects round-to-nearest scaling instead of truncation.
module hist_eq_lut_builder
  import hist_pkg::*;
#(
  parameter int unsigned FRAME_LOG2 = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [PIX_W-1:0] hist_addr,
  input  logic [BIN_W-1:0] hist_data,
  output logic             busy,
  output logic             lut_ready,
  input  logic [PIX_W-1:0] map_in_pixel,
  input  logic             map_in_valid,
  output logic [PIX_W-1:0] map_out_pixel,
  output logic             map_out_valid
);

  localparam int unsigned CDF_W  = FRAME_LOG2 + 1;
  localparam int unsigned PROD_W = FRAME_LOG2 + 9;
  localparam int unsigned SUM_W  = ((CDF_W > BIN_W) ? CDF_W : BIN_W) + 1;
  localparam logic [CDF_W-1:0] CDF_MAX = {1'b1, {FRAME_LOG2{1'b0}}};
`ifdef HIST_EQ_ROUND_EN
  localparam logic [PROD_W-1:0] RND = PROD_W'(1) << (FRAME_LOG2 - 1);
`endif

  hist_state_e      state_q, state_d;
  logic [PIX_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [PIX_W-1:0] hist_addr_d;
  logic             busy_d, lut_ready_d;
  logic             iss_vld_q, iss_vld_d;
  logic             dat_vld_q;
  logic [PIX_W-1:0] wr_idx_q, wr_idx_d;
  logic [CDF_W-1:0] cdf_q, cdf_d;

  logic [SUM_W-1:0]  sum_c;
  logic [CDF_W-1:0]  cdf_sat_c;
  logic [PROD_W-1:0] prod_c;
  logic [8:0]        scaled_c;
  logic [PIX_W-1:0]  lut_wdata_c;

  // Accumulate, saturate at the frame size and scale to 8 bits in one step,
  // so each returned bin is written to the LUT on the edge it is consumed.
  always_comb begin
    sum_c     = SUM_W'(cdf_q) + SUM_W'(hist_data);
    cdf_sat_c = (sum_c > SUM_W'(CDF_MAX)) ? CDF_MAX : CDF_W'(sum_c);
    prod_c    = PROD_W'(cdf_sat_c) * PROD_W'(PIX_MAX);
`ifdef HIST_EQ_ROUND_EN
    prod_c    = prod_c + RND;
`endif
    scaled_c    = 9'(prod_c >> FRAME_LOG2);
    lut_wdata_c = (scaled_c > 9'(PIX_MAX)) ? PIX_W'(PIX_MAX) : scaled_c[PIX_W-1:0];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    hist_addr_d = hist_addr;
    busy_d      = busy;
    lut_ready_d = lut_ready;
    iss_vld_d   = 1'b0;
    wr_idx_d    = wr_idx_q;
    cdf_d       = cdf_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_READ;
          rd_cnt_d    = '0;
          hist_addr_d = '0;
          busy_d      = 1'b1;
          lut_ready_d = 1'b0;
          wr_idx_d    = '0;
          cdf_d       = '0;
        end
      end
      ST_READ: begin
        hist_addr_d = rd_cnt_q;
        rd_cnt_d    = rd_cnt_q + PIX_W'(1);
        iss_vld_d   = 1'b1;
        if (rd_cnt_q == PIX_W'(PIX_MAX)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (dat_vld_q && (wr_idx_q == PIX_W'(PIX_MAX))) begin
          state_d     = ST_DONE;
          busy_d      = 1'b0;
          lut_ready_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (dat_vld_q) begin
      cdf_d    = cdf_sat_c;
      wr_idx_d = wr_idx_q + PIX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      rd_cnt_q      <= '0;
      hist_addr     <= '0;
      busy          <= 1'b0;
      lut_ready     <= 1'b0;
      iss_vld_q     <= 1'b0;
      dat_vld_q     <= 1'b0;
      wr_idx_q      <= '0;
      cdf_q         <= '0;
      map_out_valid <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      hist_addr     <= hist_addr_d;
      busy          <= busy_d;
      lut_ready     <= lut_ready_d;
      iss_vld_q     <= iss_vld_d;
      dat_vld_q     <= iss_vld_q;
      wr_idx_q      <= wr_idx_d;
      cdf_q         <= cdf_d;
      map_out_valid <= map_in_valid;
    end
  end

  // Map port uses the lut_ready value present at the sampling edge.
  hist_eq_lut_ram u_lut_ram (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (dat_vld_q),
    .wr_addr   (wr_idx_q),
    .wr_data   (lut_wdata_c),
    .rd_addr   (map_in_pixel),
    .rd_bypass (!lut_ready),
    .rd_data   (map_out_pixel)
  );

endmodule : hist_eq_lut_builder

// File: tb/tb_hist_eq_lut_builder.sv
// Scoreboard bench for hist_eq_lut_builder with a behavioural LUT model.
module tb_hist_eq_lut_builder;

  localparam int FL    = 8;
  localparam int FRAME = 1 << FL;
`ifdef HIST_EQ_ROUND_EN
  localparam int RND     = FRAME / 2;
  localparam int U_L0    = 1;
  localparam int U_L127  = 128;
`else
  localparam int RND     = 0;
  localparam int U_L0    = 0;
  localparam int U_L127  = 127;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  hist_addr;
  logic [15:0] hist_data;
  logic        busy;
  logic        lut_ready;
  logic [7:0]  map_in_pixel;
  logic        map_in_valid;
  logic [7:0]  map_out_pixel;
  logic        map_out_valid;

  hist_eq_lut_builder #(.FRAME_LOG2(FL)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .hist_addr     (hist_addr),
    .hist_data     (hist_data),
    .busy          (busy),
    .lut_ready     (lut_ready),
    .map_in_pixel  (map_in_pixel),
    .map_in_valid  (map_in_valid),
    .map_out_pixel (map_out_pixel),
    .map_out_valid (map_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Histogram memory with a registered read port.
  logic [15:0] hist_mem [256];
  always @(posedge clk) hist_data <= hist_mem[hist_addr];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int ref_lut [256];
  int pend_lut [256];
  int build_left;
  int edge_k;
  bit model_ready;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Equalisation rule: running sum clipped at the frame size, scaled to 0..255.
  function automatic void compute_pending();
    int run = 0;
    int v;
    for (int i = 0; i < 256; i++) begin
      run += int'(hist_mem[i]);
      if (run > FRAME) run = FRAME;
      v = (run * 255 + RND) / FRAME;
      pend_lut[i] = (v > 255) ? 255 : v;
    end
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst && map_out_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL map_out_unexpected: got pixel %0d, expected no output", map_out_pixel);
      end else begin
        chk("map_out_pixel", int'(map_out_pixel), exp_q.pop_front());
      end
    end
  end

  // One clock: drive at negedge, advance the model on the edge, check after it.
  task automatic step(input logic st, input logic v, input logic [7:0] p);
    start        = st;
    map_in_valid = v;
    map_in_pixel = p;
    if (v) exp_q.push_back(model_ready ? ref_lut[p] : int'(p));
    @(posedge clk);
    if (build_left > 0) begin
      build_left--;
      edge_k++;
      if (build_left == 0) begin
        model_ready = 1'b1;
        ref_lut     = pend_lut;
        build_left  = -1;
      end
    end else if (st) begin
      build_left  = 258;
      edge_k      = 0;
      model_ready = 1'b0;
      compute_pending();
    end
    @(negedge clk);
    start        = 1'b0;
    map_in_valid = 1'b0;
    chk("busy", int'(busy), int'(build_left > 0));
    chk("lut_ready", int'(lut_ready), int'(model_ready));
    if (build_left > 0 && edge_k <= 256)
      chk("hist_addr", int'(hist_addr), (edge_k == 0) ? 0 : edge_k - 1);
  endtask

  task automatic run_random(input int n, input int restart_at);
    for (int i = 1; i <= n; i++)
      step(logic'(i == restart_at), logic'($urandom_range(0, 9) < 7), 8'($urandom_range(0, 255)));
  endtask

  task automatic map_check(input string name, input logic [7:0] p, input int exp);
    step(1'b0, 1'b1, p);
    chk(name, int'(map_out_pixel), exp);
  endtask

  task automatic fill(input int val);
    for (int i = 0; i < 256; i++) hist_mem[i] = 16'(val);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_hist_addr"}, int'(hist_addr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_lut_ready"}, int'(lut_ready), 0);
    chk({tag, "_map_out_pixel"}, int'(map_out_pixel), 0);
    chk({tag, "_map_out_valid"}, int'(map_out_valid), 0);
  endtask

  // Asynchronous reset asserted mid-cycle, released at the next falling edge.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 chk_zero_outputs(tag);
    build_left  = -1;
    model_ready = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst          = 1'b0;
    start        = 1'b0;
    map_in_valid = 1'b0;
    map_in_pixel = '0;
    build_left   = -1;
    edge_k       = 0;
    model_ready  = 1'b0;
    fill(0);
    repeat (2) @(negedge clk);
    chk_zero_outputs("por");
    rst = 1'b1;

    // Pass-through before any LUT exists.
    map_check("passthru_37", 8'd37, 37);

    // Uniform histogram with an ignored second start at E100.
    fill(1);
    step(1'b1, 1'b1, 8'd12);
    run_random(300, 100);
    map_check("uniform_lut0", 8'd0, U_L0);
    map_check("uniform_lut127", 8'd127, U_L127);
    map_check("uniform_lut255", 8'd255, 255);

    // Single-bin histogram; start in DONE coincides with a pixel.
    fill(0);
    hist_mem[0] = 16'd256;
    step(1'b1, 1'b1, 8'd127);
    map_check("rebuild_passthru_200", 8'd200, 200);
    run_random(270, 0);
    map_check("single_lut200", 8'd200, 255);
    map_check("single_lut0", 8'd0, 255);

    // Overfull histogram: CDF saturates half-way through.
    fill(2);
    step(1'b1, 1'b0, 8'd0);
    run_random(270, 0);
    map_check("overfull_lut126", 8'd126, (254 * 255 + RND) / 256);
    map_check("overfull_lut127", 8'd127, 255);
    map_check("overfull_lut255", 8'd255, 255);

    // Abort mid-build, then rebuild from a random histogram.
    for (int i = 0; i < 256; i++) hist_mem[i] = 16'($urandom_range(0, 2));
    step(1'b1, 1'b1, 8'd5);
    run_random(150, 0);
    do_reset("abort");
    map_check("abort_passthru_99", 8'd99, 99);
    step(1'b1, 1'b0, 8'd0);
    run_random(300, 0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));

    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_hist_eq_lut_builder
